// File: rtl/apple_sprite_fetch.sv
// Apple sprite fetch stage: maps VGA pixels onto the apple sprite, drives the index ROM
// and runs the apple's hidden / whole / sliced life cycle.
module apple_sprite_fetch #(
  parameter int SPR_W      = 32,
  parameter int SPR_H      = 32,
  parameter int ADDR_W     = 10,
  parameter int TRANSP_IDX = 26,
  parameter int SPLIT_STEP = 2,
  parameter int MAX_SPLIT  = 48
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              frame_start,
  input  logic              pixel_valid,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [10:0]       sprite_x,
  input  logic [10:0]       sprite_y,
  input  logic              spawn,
  input  logic              slice,
  input  logic              clear,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [7:0]        pix_index,
  output logic              pix_hit,
  output logic              pix_valid,
  output logic              sliced_done
);

  localparam int OFF_W = $clog2(MAX_SPLIT + SPLIT_STEP + 1);
  localparam logic signed [11:0] W_S    = 12'(SPR_W);
  localparam logic signed [11:0] HALF_S = 12'(SPR_W / 2);
  localparam logic signed [11:0] H_S    = 12'(SPR_H);
  localparam logic [11:0]        W_U    = 12'(SPR_W);

  typedef enum logic [1:0] {IDLE, WHOLE, SPLIT, DONE} state_t;

  state_t             state_q, state_d;
  logic [OFF_W-1:0]   split_off_q, split_off_d, off_step;
  logic [10:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;

  logic signed [11:0] relx, rely, off_s, u_l, u_r, u_c;
  logic               row_ok, col_ok;

  logic               s0_hit_q, s0_hit_d, s0_valid_q, s0_valid_d;
  logic [11:0]        s0_u_q, s0_u_d, s0_row_q, s0_row_d;
  logic               s1_hit_q, s1_hit_d, s1_valid_q, s1_valid_d;
  logic [ADDR_W-1:0]  rom_addr_q, rom_addr_d;
  logic [11:0]        addr_full;
  logic               s2_hit_q, s2_hit_d, s2_valid_q, s2_valid_d;
  logic [7:0]         pix_index_q, pix_index_d;
  logic               pix_hit_q, pix_hit_d, pix_valid_q, pix_valid_d;

  // Life cycle; position only moves at frame_start so a frame never tears.
  always_comb begin
    state_d     = state_q;
    split_off_d = split_off_q;
    pos_x_d     = frame_start ? sprite_x : pos_x_q;
    pos_y_d     = frame_start ? sprite_y : pos_y_q;
    off_step    = split_off_q + OFF_W'(SPLIT_STEP);
    if (clear) begin
      state_d     = IDLE;
      split_off_d = '0;
    end else if (spawn) begin
      state_d     = WHOLE;
      split_off_d = '0;
    end else begin
      case (state_q)
        WHOLE: begin
          if (slice) begin
            state_d     = SPLIT;
            split_off_d = '0;
          end
        end
        SPLIT: begin
          if (frame_start) begin
            split_off_d = off_step;
            if (off_step >= OFF_W'(MAX_SPLIT)) state_d = DONE;
          end
        end
        DONE: begin
          state_d     = IDLE;
          split_off_d = '0;
        end
        default: ;
      endcase
    end
  end

  // Pixel-to-texel mapping; the left half takes precedence where the halves overlap.
  always_comb begin
    relx   = $signed({2'b00, DrawX}) - $signed({pos_x_q[10], pos_x_q});
    rely   = $signed({2'b00, DrawY}) - $signed({pos_y_q[10], pos_y_q});
    off_s  = $signed({{(12 - OFF_W){1'b0}}, split_off_q});
    u_l    = relx + off_s;
    u_r    = relx - off_s;
    row_ok = (rely >= 12'sd0) && (rely < H_S);
    col_ok = 1'b0;
    u_c    = relx;
    case (state_q)
      WHOLE: col_ok = (relx >= 12'sd0) && (relx < W_S);
      SPLIT: begin
        if ((u_l >= 12'sd0) && (u_l < HALF_S)) begin
          col_ok = 1'b1;
          u_c    = u_l;
        end else if ((u_r >= HALF_S) && (u_r < W_S)) begin
          col_ok = 1'b1;
          u_c    = u_r;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    s0_valid_d  = pixel_valid;
    s0_hit_d    = pixel_valid && row_ok && col_ok;
    s0_u_d      = u_c;
    s0_row_d    = rely;
    addr_full   = s0_row_q * W_U + s0_u_q;
    s1_valid_d  = s0_valid_q;
    s1_hit_d    = s0_hit_q;
    rom_addr_d  = s0_hit_q ? ADDR_W'(addr_full) : '0;
    s2_valid_d  = s1_valid_q;
    s2_hit_d    = s1_hit_q;
    pix_valid_d = s2_valid_q;
    pix_index_d = s2_hit_q ? rom_data : 8'd0;
    pix_hit_d   = s2_hit_q && (rom_data != 8'(TRANSP_IDX));
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      split_off_q <= '0;
      pos_x_q     <= '0;
      pos_y_q     <= '0;
      s0_hit_q    <= 1'b0;
      s0_valid_q  <= 1'b0;
      s0_u_q      <= '0;
      s0_row_q    <= '0;
      s1_hit_q    <= 1'b0;
      s1_valid_q  <= 1'b0;
      rom_addr_q  <= '0;
      s2_hit_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      pix_index_q <= '0;
      pix_hit_q   <= 1'b0;
      pix_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      split_off_q <= split_off_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      s0_hit_q    <= s0_hit_d;
      s0_valid_q  <= s0_valid_d;
      s0_u_q      <= s0_u_d;
      s0_row_q    <= s0_row_d;
      s1_hit_q    <= s1_hit_d;
      s1_valid_q  <= s1_valid_d;
      rom_addr_q  <= rom_addr_d;
      s2_hit_q    <= s2_hit_d;
      s2_valid_q  <= s2_valid_d;
      pix_index_q <= pix_index_d;
      pix_hit_q   <= pix_hit_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  assign rom_addr    = rom_addr_q;
  assign pix_index   = pix_index_q;
  assign pix_hit     = pix_hit_q;
  assign pix_valid   = pix_valid_q;
  assign sliced_done = (state_q == DONE);

endmodule

// File: tb/tb_apple_sprite_fetch.sv
// Bench for apple_sprite_fetch: directed scenarios plus randomized streaming, checked
// against a placement-based model of the apple and a 3-deep expected-output history.
module tb_apple_sprite_fetch;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        frame_start = 1'b0, pixel_valid = 1'b0;
  logic        spawn = 1'b0, slice = 1'b0, clear = 1'b0;
  logic [9:0]  DrawX = '0, DrawY = '0;
  logic [10:0] sprite_x = '0, sprite_y = '0;
  logic [9:0]  rom_addr;
  logic [7:0]  rom_data, pix_index;
  logic        pix_hit, pix_valid, sliced_done;
  logic [20:0] dut_vec;

  logic [7:0]  mem [1024];

  int m_mode;  // 0 hidden, 1 whole, 2 split, 3 done pulse
  int m_off, m_px, m_py;
  int h_valid[4], h_hit[4], h_addr[4];
  int n_checks = 0, n_pass = 0;

  apple_sprite_fetch dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .DrawX(DrawX), .DrawY(DrawY), .sprite_x(sprite_x), .sprite_y(sprite_y),
    .spawn(spawn), .slice(slice), .clear(clear), .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_index(pix_index), .pix_hit(pix_hit), .pix_valid(pix_valid), .sliced_done(sliced_done)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) rom_data <= mem[rom_addr];
  assign dut_vec = {rom_addr, pix_index, pix_hit, pix_valid, sliced_done};

  function automatic void model_reset();
    m_mode = 0; m_off = 0; m_px = 0; m_py = 0;
    for (int i = 0; i < 4; i++) begin
      h_valid[i] = 0; h_hit[i] = 0; h_addr[i] = 0;
    end
  endfunction

  // Which texel, if any, the apple places on screen pixel (dx,dy).
  function automatic void texel(input int dx, input int dy, output int hit, output int addr);
    int ry;
    hit = 0; addr = 0;
    ry = dy - m_py;
    if (ry < 0 || ry >= 32) return;
    if (m_mode == 1) begin
      if (dx - m_px >= 0 && dx - m_px < 32) begin hit = 1; addr = ry * 32 + dx - m_px; end
    end else if (m_mode == 2) begin
      for (int u = 0; u < 16; u++)
        if (hit == 0 && m_px + u - m_off == dx) begin hit = 1; addr = ry * 32 + u; end
      for (int u = 16; u < 32; u++)
        if (hit == 0 && m_px + u + m_off == dx) begin hit = 1; addr = ry * 32 + u; end
    end
  endfunction

  function automatic logic [20:0] expected();
    logic [7:0] idx;
    logic       ht;
    idx = (h_hit[3] != 0) ? mem[h_addr[3]] : 8'd0;
    ht  = (h_hit[3] != 0) && (mem[h_addr[3]] != 8'd26);
    return {10'(h_addr[1]), idx, ht, (h_valid[3] != 0), (m_mode == 3)};
  endfunction

  // One clock: model sees the same inputs the DUT samples, outputs are read at the negedge.
  task automatic step();
    int h, a;
    @(posedge Clk);
    if (!Reset_n) model_reset();
    else begin
      texel(int'(DrawX), int'(DrawY), h, a);
      if (!pixel_valid) h = 0;
      if (h == 0) a = 0;
      for (int i = 3; i > 0; i--) begin
        h_valid[i] = h_valid[i-1]; h_hit[i] = h_hit[i-1]; h_addr[i] = h_addr[i-1];
      end
      h_valid[0] = int'(pixel_valid); h_hit[0] = h; h_addr[0] = a;
      if (frame_start) begin m_px = int'($signed(sprite_x)); m_py = int'($signed(sprite_y)); end
      if (clear) begin m_mode = 0; m_off = 0; end
      else if (spawn) begin m_mode = 1; m_off = 0; end
      else if (m_mode == 3) m_mode = 0;
      else if (m_mode == 1 && slice) begin m_mode = 2; m_off = 0; end
      else if (m_mode == 2 && frame_start) begin
        m_off += 2;
        if (m_off >= 48) m_mode = 3;
      end
    end
    @(negedge Clk);
  endtask

  task automatic quiet();
    frame_start = 0; spawn = 0; slice = 0; clear = 0; pixel_valid = 0;
  endtask

  task automatic test_reset();
    quiet();
    Reset_n = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (dut_vec !== 21'd0) $display("FAIL reset[%0d]: got %h required %h", i, dut_vec, 21'd0);
      else n_pass++;
    end
    Reset_n = 1;
    $display("test_reset done");
  endtask

  task automatic test_whole();
    int xs[8] = '{100, 131, 132, 99, 115, 100, 131, 120};
    int ys[8] = '{50, 50, 50, 50, 81, 82, 60, 49};
    quiet(); spawn = 1; step();
    quiet(); sprite_x = 11'd100; sprite_y = 11'd50; frame_start = 1; step();
    quiet();
    for (int i = 0; i < 11; i++) begin
      pixel_valid = (i < 8);
      DrawX = 10'(xs[i % 8]); DrawY = 10'(ys[i % 8]);
      step();
      n_checks++;
      if (dut_vec !== expected())
        $display("FAIL whole[%0d]: got %h required %h", i, dut_vec, expected());
      else n_pass++;
    end
    $display("test_whole done");
  endtask

  task automatic test_split();
    int xs[9] = '{94, 122, 110, 109, 125, 93, 141, 78, 100};
    quiet(); slice = 1; step();
    quiet();
    for (int i = 0; i < 3; i++) begin
      frame_start = 1; step(); frame_start = 0; step();
    end
    for (int i = 0; i < 12; i++) begin
      pixel_valid = (i < 9);
      DrawX = 10'(xs[i % 9]); DrawY = 10'(50 + i);
      step();
      n_checks++;
      if (dut_vec !== expected())
        $display("FAIL split[%0d]: got %h required %h", i, dut_vec, expected());
      else n_pass++;
    end
    $display("test_split done");
  endtask

  task automatic test_done();
    quiet(); pixel_valid = 1; DrawY = 10'd60;
    for (int i = 0; i < 48; i++) begin
      frame_start = (i % 2 == 0) && (i < 42);
      slice = (i % 7 == 3);
      DrawX = 10'(60 + $urandom_range(0, 100));
      step();
      n_checks++;
      if (dut_vec !== expected())
        $display("FAIL done[%0d]: got %h required %h", i, dut_vec, expected());
      else n_pass++;
    end
    $display("test_done done");
  endtask

  task automatic test_clear_spawn();
    int xs[6] = '{0, 21, 22, 31, 5, 0};
    quiet(); spawn = 1; step();
    quiet(); spawn = 1; clear = 1; step();
    quiet(); sprite_x = 11'(-10); sprite_y = 11'd20; frame_start = 1; step();
    quiet(); pixel_valid = 1; DrawX = 10'd0; DrawY = 10'd20;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (dut_vec !== expected())
        $display("FAIL clear_spawn[%0d]: got %h required %h", i, dut_vec, expected());
      else n_pass++;
    end
    quiet(); spawn = 1; step(); quiet();
    for (int i = 0; i < 9; i++) begin
      pixel_valid = (i < 6);
      DrawX = 10'(xs[i % 6]); DrawY = 10'(20 + i);
      step();
      n_checks++;
      if (dut_vec !== expected())
        $display("FAIL offscreen[%0d]: got %h required %h", i, dut_vec, expected());
      else n_pass++;
    end
    $display("test_clear_spawn done");
  endtask

  task automatic test_async_reset();
    quiet(); spawn = 1; step(); quiet(); pixel_valid = 1;
    for (int i = 0; i < 6; i++) begin
      DrawX = 10'(int'($signed(sprite_x)) + i); DrawY = 10'(int'($signed(sprite_y)) + i); step();
    end
    #2 Reset_n = 0;
    #1;
    n_checks++;
    if (dut_vec !== 21'd0) $display("FAIL async_reset: got %h required %h", dut_vec, 21'd0);
    else n_pass++;
    step();
    Reset_n = 1;
    for (int i = 0; i < 6; i++) begin
      DrawX = 10'(i); DrawY = 10'(i);
      step();
      n_checks++;
      if (dut_vec !== expected())
        $display("FAIL after_reset[%0d]: got %h required %h", i, dut_vec, expected());
      else n_pass++;
    end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    int bx, by;
    quiet();
    for (int i = 0; i < 3000; i++) begin
      clear       = ($urandom_range(0, 99) == 0);
      spawn       = ($urandom_range(0, 39) == 0);
      slice       = ($urandom_range(0, 29) == 0);
      frame_start = ($urandom_range(0, 5) == 0);
      if (frame_start) begin
        sprite_x = 11'(int'($urandom_range(0, 300)) - 40);
        sprite_y = 11'(int'($urandom_range(0, 200)) - 30);
      end
      pixel_valid = ($urandom_range(0, 3) != 0);
      bx = m_px + int'($urandom_range(0, 140)) - 55;
      by = m_py + int'($urandom_range(0, 40)) - 4;
      DrawX = 10'((bx < 0) ? 0 : (bx > 639 ? 639 : bx));
      DrawY = 10'((by < 0) ? 0 : (by > 479 ? 479 : by));
      step();
      n_checks++;
      if (dut_vec !== expected())
        $display("FAIL random[%0d]: got %h required %h", i, dut_vec, expected());
      else n_pass++;
    end
    $display("test_random done");
  endtask

  initial begin
    for (int i = 0; i < 1024; i++)
      mem[i] = ($urandom_range(0, 3) == 0) ? 8'd26 : 8'($urandom_range(0, 255));
    mem[0] = 8'd5; mem[31] = 8'd26; mem[16] = 8'd7; mem[10] = 8'd9;
    model_reset();
    test_reset();
    test_whole();
    test_split();
    test_done();
    test_clear_spawn();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
